// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the AXI read-path scheduler.
package axi_rd_pkg;

  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_LEN_BITS  = 4;

  localparam logic [15:0] DEF_S0_HI = 16'h0000;
  localparam logic [15:0] DEF_S1_HI = 16'h0001;

  localparam logic [1:0] M0_OH = 2'b01;
  localparam logic [1:0] M1_OH = 2'b10;

  localparam logic [2:0] S0_OH = 3'b001;
  localparam logic [2:0] S1_OH = 3'b010;
  localparam logic [2:0] DS_OH = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } rd_state_e;

  function automatic logic [2:0] tgt_decode(
    input logic [15:0] hi,
    input logic [15:0] s0_hi,
    input logic [15:0] s1_hi
  );
    if (hi == s0_hi) return S0_OH;
    if (hi == s1_hi) return S1_OH;
    return DS_OH;
  endfunction

endpackage

// File: rtl/axi_rd_scheduler_rr_arb2.sv
// Two-request round-robin picker; rr_last remembers the last
// master served and only moves when a burst completes.
module rr_arb2
  import axi_rd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_m1,
  output logic [1:0] gnt
);

  logic rr_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last <= 1'b1;
    end else if (upd) begin
      rr_last <= upd_m1;
    end
  end

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11): gnt = rr_last ? M0_OH : M1_OH;
      (req == 2'b01): gnt = M0_OH;
      (req == 2'b10): gnt = M1_OH;
      default:        gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi_rd_scheduler.sv
// AXI read-path control: arbitrates AR between two masters, decodes
// the target, and gates AR/R handshakes for one burst at a time.
module axi_rd_scheduler
  import axi_rd_pkg::*;
#(
  parameter int          ADDR_W = AXI_ADDR_BITS,
  parameter int          LEN_W  = AXI_LEN_BITS,
  parameter logic [15:0] S0_HI  = DEF_S0_HI,
  parameter logic [15:0] S1_HI  = DEF_S1_HI
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ARVALID_M0,
  input  logic              ARVALID_M1,
  input  logic [ADDR_W-1:0] ARADDR_M0,
  input  logic [ADDR_W-1:0] ARADDR_M1,
  input  logic [LEN_W-1:0]  ARLEN_M0,
  input  logic [LEN_W-1:0]  ARLEN_M1,
  output logic              ARREADY_M0,
  output logic              ARREADY_M1,
  output logic              ARVALID_S0,
  output logic              ARVALID_S1,
  output logic              ARVALID_DS,
  input  logic              ARREADY_S0,
  input  logic              ARREADY_S1,
  input  logic              ARREADY_DS,
  input  logic              RVALID_S0,
  input  logic              RVALID_S1,
  input  logic              RVALID_DS,
  input  logic              RLAST_S0,
  input  logic              RLAST_S1,
  input  logic              RLAST_DS,
  output logic              RREADY_S0,
  output logic              RREADY_S1,
  output logic              RREADY_DS,
  output logic              RVALID_M0,
  output logic              RVALID_M1,
  input  logic              RREADY_M0,
  input  logic              RREADY_M1,
  output logic [1:0]        grant_m,
  output logic [2:0]        sel_s,
  output logic              busy,
  output logic              len_err
);

  rd_state_e        state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;
  logic [LEN_W-1:0] len_m;
  logic [1:0]       req;
  logic [1:0]       gnt;
  logic [1:0]       rr_m;
  logic [2:0]       arr_s;
  logic [2:0]       rv_s;
  logic [2:0]       rl_s;
  logic [2:0]       tgt;
  logic [15:0]      hi;
  logic             ar_v;
  logic             ar_r;
  logic             r_v;
  logic             r_r;
  logic             r_l;
  logic             ar_hs;
  logic             r_hs;
  logic             done;
  logic             in_addr;
  logic             in_data;
  logic             unused;

  assign unused = ^{ARADDR_M0[ADDR_W-17:0], ARADDR_M1[ADDR_W-17:0]};

  assign req   = {ARVALID_M1, ARVALID_M0};
  assign rr_m  = {RREADY_M1, RREADY_M0};
  assign arr_s = {ARREADY_DS, ARREADY_S1, ARREADY_S0};
  assign rv_s  = {RVALID_DS, RVALID_S1, RVALID_S0};
  assign rl_s  = {RLAST_DS, RLAST_S1, RLAST_S0};

  assign in_addr = (state == ADDR);
  assign in_data = (state == DATA);

  // All routing keys off the registered selects only.
  assign ar_v  = |(grant_m & req);
  assign ar_r  = |(sel_s & arr_s);
  assign r_v   = |(sel_s & rv_s);
  assign r_r   = |(grant_m & rr_m);
  assign r_l   = |(sel_s & rl_s);
  assign ar_hs = in_addr & ar_v & ar_r;
  assign r_hs  = in_data & r_v & r_r;
  assign done  = r_hs & r_l;

  assign hi = gnt[1] ? ARADDR_M1[ADDR_W-1 -: 16]
                     : ARADDR_M0[ADDR_W-1 -: 16];
  assign tgt   = tgt_decode(hi, S0_HI, S1_HI);
  assign len_m = grant_m[1] ? ARLEN_M1 : ARLEN_M0;

  assign {ARVALID_DS, ARVALID_S1, ARVALID_S0} =
    (in_addr && ar_v) ? sel_s : 3'b000;
  assign {ARREADY_M1, ARREADY_M0} =
    (in_addr && ar_r) ? grant_m : 2'b00;
  assign {RVALID_M1, RVALID_M0} =
    (in_data && r_v) ? grant_m : 2'b00;
  assign {RREADY_DS, RREADY_S1, RREADY_S0} =
    (in_data && r_r) ? sel_s : 3'b000;

  assign busy = (state != IDLE);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .upd    (done),
    .upd_m1 (grant_m[1]),
    .gnt    (gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_m  <= 2'b00;
      sel_s    <= 3'b000;
      len_q    <= '0;
      beat_cnt <= '0;
      len_err  <= 1'b0;
    end else begin
      len_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            grant_m <= gnt;
            sel_s   <= tgt;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (ar_hs) begin
            len_q    <= len_m;
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            if (beat_cnt != '1) begin
              beat_cnt <= beat_cnt + LEN_W'(1);
            end
            // Compare the pre-increment count: last beat index vs ARLEN.
            if (r_l) begin
              len_err <= (beat_cnt != len_q);
              grant_m <= 2'b00;
              sel_s   <= 3'b000;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_scheduler.sv
// Bench for axi_rd_scheduler: transaction-level model checked every
// cycle, directed scenarios with literal expectations, random traffic.
module tb_axi_rd_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  arv_m;
  logic [1:0]  rr_m;
  logic [31:0] addr_m [2];
  logic [3:0]  len_m [2];
  logic [2:0]  arr_s;
  logic [2:0]  rv_s;
  logic [2:0]  rl_s;

  logic arr_m0, arr_m1, ars0, ars1, ards;
  logic rrs0, rrs1, rrds, rvm0, rvm1;
  logic [1:0] grant_m;
  logic [2:0] sel_s;
  logic busy, len_err;

  axi_rd_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .ARVALID_M0 (arv_m[0]),
    .ARVALID_M1 (arv_m[1]),
    .ARADDR_M0  (addr_m[0]),
    .ARADDR_M1  (addr_m[1]),
    .ARLEN_M0   (len_m[0]),
    .ARLEN_M1   (len_m[1]),
    .ARREADY_M0 (arr_m0),
    .ARREADY_M1 (arr_m1),
    .ARVALID_S0 (ars0),
    .ARVALID_S1 (ars1),
    .ARVALID_DS (ards),
    .ARREADY_S0 (arr_s[0]),
    .ARREADY_S1 (arr_s[1]),
    .ARREADY_DS (arr_s[2]),
    .RVALID_S0  (rv_s[0]),
    .RVALID_S1  (rv_s[1]),
    .RVALID_DS  (rv_s[2]),
    .RLAST_S0   (rl_s[0]),
    .RLAST_S1   (rl_s[1]),
    .RLAST_DS   (rl_s[2]),
    .RREADY_S0  (rrs0),
    .RREADY_S1  (rrs1),
    .RREADY_DS  (rrds),
    .RVALID_M0  (rvm0),
    .RVALID_M1  (rvm1),
    .RREADY_M0  (rr_m[0]),
    .RREADY_M1  (rr_m[1]),
    .grant_m    (grant_m),
    .sel_s      (sel_s),
    .busy       (busy),
    .len_err    (len_err)
  );

  int n_assert = 0;
  int n_fail = 0;

  // transaction-level model
  bit m_busy, m_ph, m_err;
  int m_mst, m_tgt, m_len, m_beats, m_last;

  // auto-responder configuration
  bit          rnd;
  int          pend [2];
  logic [31:0] cfg_addr [2];
  int          cfg_len [2];
  int          rlast_at, bp_at, bp_left;

  // observations
  int beats_m [2];
  int err_cnt, cyc, ars01_cnt, bp_stall;
  bit s_busy, prev_busy;
  int rise_q[$], rlast_q[$], err_q[$];
  logic [1:0] gnt_q[$];

  task automatic chk(input string n, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_ph = 0; m_err = 0;
    m_mst = 0; m_tgt = 0; m_len = 0;
    m_beats = 0; m_last = 1;
  endtask

  task automatic drive_auto();
    for (int m = 0; m < 2; m++) begin
      arv_m[m]  = (pend[m] > 0);
      addr_m[m] = cfg_addr[m];
      len_m[m]  = 4'(cfg_len[m]);
    end
    arr_s = 3'b111;
    rv_s  = 3'b111;
    rl_s  = 3'b111;
    if (m_busy && m_ph) rl_s[m_tgt] = (m_beats + 1 == rlast_at);
    rr_m = 2'b11;
    if (bp_left > 0 && m_busy && m_ph && m_beats == bp_at)
      rr_m[m_mst] = 1'b0;
  endtask

  task automatic drive_rand();
    for (int m = 0; m < 2; m++) begin
      arv_m[m] = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       addr_m[m] = {16'h0000, 16'($urandom)};
        1:       addr_m[m] = {16'h0001, 16'($urandom)};
        default: addr_m[m] = $urandom;
      endcase
      len_m[m] = ($urandom_range(0, 7) == 0) ? 4'($urandom)
                                             : 4'($urandom_range(0, 3));
    end
    arr_s = 3'($urandom);
    rv_s  = 3'($urandom);
    rl_s  = {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0};
    rr_m  = {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0};
  endtask

  // One clock: drive, check against the model, advance the model.
  task automatic tick();
    bit bp_act, n_busy, n_ph, n_err, hs0, hs1;
    int n_mst, n_tgt, n_len, n_beats, n_last;
    logic [15:0] hi;
    logic [1:0] e_g, e_arm, e_rvm;
    logic [2:0] e_s, e_ars, e_rrs;
    bp_act = 0;
    if (rnd) drive_rand();
    else begin
      drive_auto();
      bp_act = (rr_m != 2'b11);
    end
    #1;
    e_g   = m_busy ? 2'(1 << m_mst) : 2'b00;
    e_s   = m_busy ? 3'(1 << m_tgt) : 3'b000;
    e_ars = (m_busy && !m_ph && arv_m[m_mst]) ? e_s : 3'b000;
    e_arm = (m_busy && !m_ph && arr_s[m_tgt]) ? e_g : 2'b00;
    e_rvm = (m_busy && m_ph && rv_s[m_tgt]) ? e_g : 2'b00;
    e_rrs = (m_busy && m_ph && rr_m[m_mst]) ? e_s : 3'b000;
    chk("grant_m", int'(grant_m), int'(e_g));
    chk("sel_s", int'(sel_s), int'(e_s));
    chk("busy", int'(busy), int'(m_busy));
    chk("len_err", int'(len_err), int'(m_err));
    chk("arvalid_s", int'({ards, ars1, ars0}), int'(e_ars));
    chk("arready_m", int'({arr_m1, arr_m0}), int'(e_arm));
    chk("rvalid_m", int'({rvm1, rvm0}), int'(e_rvm));
    chk("rready_s", int'({rrds, rrs1, rrs0}), int'(e_rrs));

    s_busy = busy;
    if (busy && !prev_busy) begin
      gnt_q.push_back(grant_m);
      rise_q.push_back(cyc);
    end
    prev_busy = busy;
    beats_m[0] += int'(rvm0 & rr_m[0]);
    beats_m[1] += int'(rvm1 & rr_m[1]);
    if (((rvm0 & rr_m[0]) | (rvm1 & rr_m[1])) && |(sel_s & rl_s))
      rlast_q.push_back(cyc);
    if (len_err) begin
      err_cnt++;
      err_q.push_back(cyc);
    end
    if (ars0 | ars1) ars01_cnt++;
    if (bp_act && rv_s[0] && !rrs0) bp_stall++;
    hs0 = arv_m[0] & arr_m0;
    hs1 = arv_m[1] & arr_m1;

    n_busy = m_busy; n_ph = m_ph; n_err = 0;
    n_mst = m_mst; n_tgt = m_tgt; n_len = m_len;
    n_beats = m_beats; n_last = m_last;
    if (!m_busy) begin
      if (arv_m != 2'b00) begin
        if (arv_m == 2'b11) n_mst = (m_last == 1) ? 0 : 1;
        else n_mst = arv_m[0] ? 0 : 1;
        hi = addr_m[n_mst][31:16];
        n_tgt = (hi == 16'h0000) ? 0 : (hi == 16'h0001) ? 1 : 2;
        n_busy = 1; n_ph = 0;
      end
    end else if (!m_ph) begin
      if (arv_m[m_mst] && arr_s[m_tgt]) begin
        n_len = int'(len_m[m_mst]);
        n_beats = 0; n_ph = 1;
      end
    end else if (rv_s[m_tgt] && rr_m[m_mst]) begin
      if (rl_s[m_tgt]) begin
        n_err = (((m_beats > 15) ? 15 : m_beats) != m_len);
        n_last = m_mst; n_busy = 0; n_ph = 0;
      end else begin
        n_beats = m_beats + 1;
      end
    end

    @(posedge clk);
    m_busy = n_busy; m_ph = n_ph; m_err = n_err;
    m_mst = n_mst; m_tgt = n_tgt; m_len = n_len;
    m_beats = n_beats; m_last = n_last;
    if (!rnd) begin
      if (hs0 && pend[0] > 0) pend[0]--;
      if (hs1 && pend[1] > 0) pend[1]--;
      if (bp_act) bp_left--;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until_idle(output int n);
    bit seen, ok;
    seen = 0; ok = 0; n = 0;
    while (n < 400 && !ok) begin
      tick();
      n++;
      if (s_busy) seen = 1;
      else if (seen) ok = 1;
    end
    chk("run_bound", int'(ok), 1);
  endtask

  task automatic setup(input int m, input logic [31:0] a,
                       input int len, input int rl);
    cfg_addr[m] = a;
    cfg_len[m] = len;
    rlast_at = rl;
    pend[m] = 1;
  endtask

  initial begin
    int n, b0, b1, e0, q0, r0, st0, a0;
    rnd = 0; pend[0] = 0; pend[1] = 0;
    bp_at = 0; bp_left = 0; rlast_at = 1;
    cfg_addr[0] = '0; cfg_addr[1] = '0;
    cfg_len[0] = 0; cfg_len[1] = 0;
    beats_m[0] = 0; beats_m[1] = 0;
    err_cnt = 0; cyc = 0; ars01_cnt = 0; bp_stall = 0;
    s_busy = 0; prev_busy = 0;
    arv_m = '0; rr_m = '0; arr_s = '0; rv_s = '0; rl_s = '0;
    addr_m[0] = '0; addr_m[1] = '0; len_m[0] = '0; len_m[1] = '0;
    model_reset();

    #1;
    chk("reset_grant", int'(grant_m), 0);
    chk("reset_sel", int'(sel_s), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_gates", int'({ars0, ars1, ards, arr_m0, arr_m1,
                             rrs0, rrs1, rrds, rvm0, rvm1, len_err}), 0);
    @(negedge clk);
    rst = 1'b0;

    // contention: M0 first after reset, then alternation
    cfg_addr[0] = 32'h0000_0100; cfg_addr[1] = 32'h0000_0200;
    cfg_len[0] = 0; cfg_len[1] = 0; rlast_at = 1;
    pend[0] = 2; pend[1] = 1;
    q0 = gnt_q.size(); r0 = rlast_q.size();
    run_until_idle(n);
    run_until_idle(n);
    run_until_idle(n);
    chk("rr_grant0", int'(gnt_q[q0]), 1);
    chk("rr_grant1", int'(gnt_q[q0+1]), 2);
    chk("rr_grant2", int'(gnt_q[q0+2]), 1);
    // RLAST at r, grant registered in the r+1 IDLE cycle, busy at r+2
    chk("rr_gap1", rise_q[q0+1] - rlast_q[r0], 2);
    chk("rr_gap2", rise_q[q0+2] - rlast_q[r0+1], 2);

    // single read to S1
    setup(0, 32'h0001_0040, 3, 4);
    b0 = beats_m[0]; e0 = err_cnt;
    tick();
    drive_auto();
    #1;
    chk("t1_arvalid_s1", int'(ars1), 1);
    chk("t1_sel", int'(sel_s), 3'b010);
    run_until_idle(n);
    chk("t1_cycles", n, 6);
    chk("t1_beats", beats_m[0] - b0, 4);
    chk("t1_busy_drop", cyc - 1 - rlast_q[$], 1);
    chk("t1_len_err", err_cnt - e0, 0);

    // default slave decode
    setup(1, 32'h0005_0000, 0, 1);
    b1 = beats_m[1]; a0 = ars01_cnt;
    tick();
    drive_auto();
    #1;
    chk("ds_sel", int'(sel_s), 3'b100);
    chk("ds_grant", int'(grant_m), 2'b10);
    run_until_idle(n);
    chk("ds_no_s01", ars01_cnt - a0, 0);
    chk("ds_beats", beats_m[1] - b1, 1);

    // early RLAST
    setup(0, 32'h0000_0000, 3, 2);
    e0 = err_cnt;
    run_until_idle(n);
    chk("short_err", err_cnt - e0, 1);
    chk("short_err_t", err_q[$] - rlast_q[$], 1);

    // late RLAST
    setup(0, 32'h0001_0000, 1, 4);
    e0 = err_cnt; b0 = beats_m[0];
    run_until_idle(n);
    chk("long_err", err_cnt - e0, 1);
    chk("long_err_t", err_q[$] - rlast_q[$], 1);
    chk("long_beats", beats_m[0] - b0, 4);

    // master backpressure for 5 cycles after beat 2
    setup(0, 32'h0000_0010, 3, 4);
    bp_at = 2; bp_left = 5;
    e0 = err_cnt; b0 = beats_m[0]; st0 = bp_stall;
    run_until_idle(n);
    chk("bp_cycles", n, 12);
    chk("bp_beats", beats_m[0] - b0, 4);
    chk("bp_stalls", bp_stall - st0, 5);
    chk("bp_err", err_cnt - e0, 0);

    // async reset during beat 2
    setup(1, 32'h0001_0000, 3, 4);
    n = 0;
    while (!(m_busy && m_ph && m_beats == 1) && n < 20) begin
      tick();
      n++;
    end
    chk("rst_reach", int'(m_busy && m_ph && m_beats == 1), 1);
    drive_auto();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_outputs", int'({grant_m, sel_s, busy, len_err, ars0, ars1,
                             ards, arr_m0, arr_m1, rvm0, rvm1, rrs0,
                             rrs1, rrds}), 0);
    model_reset();
    pend[0] = 0; pend[1] = 0; bp_left = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    prev_busy = 0;
    setup(1, 32'h0000_0300, 3, 4);
    b1 = beats_m[1]; e0 = err_cnt;
    run_until_idle(n);
    chk("post_rst_grant", int'(gnt_q[$]), 2'b10);
    chk("post_rst_beats", beats_m[1] - b1, 4);
    chk("post_rst_err", err_cnt - e0, 0);

    // random traffic, including protocol abuse and spurious targets
    rnd = 1;
    repeat (3000) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
